// File: rtl/ctrl_bin_sched.sv
// Bin scheduler: walks bins 0..N-1 through load/core/update, with global backtrack on conflicts.
// Optional core watchdog is compiled in by defining CTRL_BIN_SCHED_WDT_EN.
module ctrl_bin_sched #(
    parameter int WIDTH_BIN_ID = 10,
    parameter int WIDTH_LVL    = 16,
    parameter int WDT_CYCLES   = 65535
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic [WIDTH_BIN_ID-1:0] num_bins_i,
    output logic                    start_load_o,
    input  logic                    done_load_i,
    output logic                    start_core_o,
    input  logic                    done_core_i,
    input  logic                    core_sat_i,
    input  logic                    core_unsat_i,
    input  logic [WIDTH_BIN_ID-1:0] bkt_bin_num_i,
    input  logic [WIDTH_LVL-1:0]    bkt_lvl_i,
    output logic                    core_clr_o,
    output logic                    start_update_o,
    input  logic                    done_update_i,
    output logic                    apply_gbkt_o,
    input  logic                    done_gbkt_i,
    output logic [WIDTH_BIN_ID-1:0] cur_bin_num_o,
    output logic                    done_o,
    output logic                    global_sat_o,
    output logic                    global_unsat_o,
    output logic                    wdt_err_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        CORE   = 3'd2,
        UPDATE = 3'd3,
        NEXT   = 3'd4,
        GBKT   = 3'd5,
        SAT    = 3'd6,
        UNSAT  = 3'd7
    } state_t;

    state_t                  state_r;
    logic [WIDTH_BIN_ID-1:0] num_bins_r;
    logic [WIDTH_BIN_ID-1:0] bkt_bin_r;
    logic                    core_min_r;
    logic                    core_exit_s;
    logic                    last_bin_s;
    logic                    wdt_trip_s;

    // A stale sticky done must not end CORE before the core has seen its start pulse.
    assign core_exit_s = done_core_i && core_min_r && (core_sat_i || core_unsat_i);
    assign last_bin_s  = (cur_bin_num_o == (num_bins_r - WIDTH_BIN_ID'(1)));

`ifdef CTRL_BIN_SCHED_WDT_EN
    logic [31:0] wdt_cnt_r;

    // Watchdog counter: held at zero in LOAD so every CORE visit starts from zero
    always_ff @(posedge clk) begin
        if (!rst) begin
            wdt_cnt_r <= 32'd0;
        end else if (state_r == LOAD) begin
            wdt_cnt_r <= 32'd0;
        end else if (state_r == CORE) begin
            wdt_cnt_r <= wdt_cnt_r + 32'd1;
        end else begin
            wdt_cnt_r <= wdt_cnt_r;
        end
    end

    assign wdt_trip_s = (state_r == CORE) && (wdt_cnt_r == 32'(WDT_CYCLES)) && !done_core_i;
`else
    assign wdt_trip_s = 1'b0;
`endif

    // Scheduler FSM with registered request pulses and sticky completion flags
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r        <= IDLE;
            num_bins_r     <= WIDTH_BIN_ID'(0);
            bkt_bin_r      <= WIDTH_BIN_ID'(0);
            core_min_r     <= 1'b0;
            cur_bin_num_o  <= WIDTH_BIN_ID'(0);
            start_load_o   <= 1'b0;
            start_core_o   <= 1'b0;
            start_update_o <= 1'b0;
            apply_gbkt_o   <= 1'b0;
            core_clr_o     <= 1'b0;
            done_o         <= 1'b0;
            global_sat_o   <= 1'b0;
            global_unsat_o <= 1'b0;
            wdt_err_o      <= 1'b0;
        end else begin
            start_load_o   <= 1'b0;
            start_core_o   <= 1'b0;
            start_update_o <= 1'b0;
            apply_gbkt_o   <= 1'b0;
            core_clr_o     <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start_i) begin
                        num_bins_r     <= num_bins_i;
                        cur_bin_num_o  <= WIDTH_BIN_ID'(0);
                        done_o         <= 1'b0;
                        global_sat_o   <= 1'b0;
                        global_unsat_o <= 1'b0;
                        wdt_err_o      <= 1'b0;
                        start_load_o   <= 1'b1;
                        state_r        <= LOAD;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                LOAD: begin
                    if (done_load_i) begin
                        core_min_r   <= 1'b0;
                        start_core_o <= 1'b1;
                        state_r      <= CORE;
                    end else begin
                        state_r <= LOAD;
                    end
                end
                CORE: begin
                    core_min_r <= 1'b1;
                    if (core_exit_s) begin
                        core_clr_o <= 1'b1;
                        if (core_sat_i) begin
                            start_update_o <= 1'b1;
                            state_r        <= UPDATE;
                        end else if (bkt_lvl_i == WIDTH_LVL'(0)) begin
                            state_r <= UNSAT;
                        end else begin
                            bkt_bin_r    <= bkt_bin_num_i;
                            apply_gbkt_o <= 1'b1;
                            state_r      <= GBKT;
                        end
                    end else if (wdt_trip_s) begin
                        core_clr_o <= 1'b1;
                        wdt_err_o  <= 1'b1;
                        done_o     <= 1'b1;
                        state_r    <= IDLE;
                    end else begin
                        state_r <= CORE;
                    end
                end
                UPDATE: begin
                    if (done_update_i) begin
                        state_r <= NEXT;
                    end else begin
                        state_r <= UPDATE;
                    end
                end
                NEXT: begin
                    if (last_bin_s) begin
                        state_r <= SAT;
                    end else begin
                        cur_bin_num_o <= cur_bin_num_o + WIDTH_BIN_ID'(1);
                        start_load_o  <= 1'b1;
                        state_r       <= LOAD;
                    end
                end
                GBKT: begin
                    if (done_gbkt_i) begin
                        cur_bin_num_o <= bkt_bin_r;
                        start_load_o  <= 1'b1;
                        state_r       <= LOAD;
                    end else begin
                        state_r <= GBKT;
                    end
                end
                SAT: begin
                    global_sat_o <= 1'b1;
                    done_o       <= 1'b1;
                    state_r      <= IDLE;
                end
                UNSAT: begin
                    global_unsat_o <= 1'b1;
                    done_o         <= 1'b1;
                    state_r        <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule
